// File: rtl/fir_in_seq_if.sv
// Host-side word bus and FIR-side sample/coefficient bus of the FIR input sequencer.
// The host drives the master side; the sequencer is the slave.
interface fir_in_seq_if #(
   parameter int DATA_W = 6
);
   logic [DATA_W-1:0] host_data;
   logic              host_valid;
   logic              host_mode;
   logic              host_ready;
   logic [DATA_W-1:0] fir_tdata;
   logic              fir_tvalid;
   logic              fir_set_coeffs;

   modport master (
      output host_data, host_valid, host_mode,
      input  host_ready, fir_tdata, fir_tvalid, fir_set_coeffs
   );

   modport slave (
      input  host_data, host_valid, host_mode,
      output host_ready, fir_tdata, fir_tvalid, fir_set_coeffs
   );
endinterface

// File: rtl/fir_in_seq.sv
// Input sequencer for the FIR stage: queues samples, streams one per cycle, and packs
// coefficient words into a burst that never overlaps sample traffic.
module fir_in_seq #(
   parameter int DATA_W     = 6,
   parameter int FIFO_DEPTH = 4,
   parameter int COEF_WORDS = 3
) (
   input  logic        clk,
   input  logic        reset,
   fir_in_seq_if.slave bus,
   output logic        ovf,
   output logic        coef_err
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CC_W  = $clog2(COEF_WORDS + 1);
   localparam int IX_W  = (COEF_WORDS > 1) ? $clog2(COEF_WORDS) : 1;

   typedef enum logic [2:0] {
      ST_STREAM,
      ST_COLLECT,
      ST_DRAIN,
      ST_ISSUE,
      ST_GAP
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_nxt;
   logic [DATA_W-1:0] coef_mem [COEF_WORDS];
   logic [CC_W-1:0]   coef_cnt;
   logic [IX_W-1:0]   issue_idx;

   logic accepting, fifo_full, fifo_empty;
   logic push, pop, coef_take, abort, last_coef, last_issue;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      accepting      = (state == ST_STREAM) || (state == ST_COLLECT);
      fifo_full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
      fifo_empty     = (fifo_cnt == '0);
      bus.host_ready = reset && accepting && !fifo_full;
      push           = bus.host_valid && bus.host_ready && !bus.host_mode;
      coef_take      = bus.host_valid && bus.host_ready && bus.host_mode;
      abort          = push && (state == ST_COLLECT);
      pop            = ((state == ST_STREAM) || (state == ST_DRAIN)) && !fifo_empty;
      fifo_cnt_nxt   = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      last_coef      = coef_take && (coef_cnt == CC_W'(COEF_WORDS - 1));
      last_issue     = (issue_idx == IX_W'(COEF_WORDS - 1));
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_STREAM, ST_COLLECT: begin
            if (abort)          state_nxt = ST_STREAM;
            else if (last_coef) state_nxt = (fifo_cnt_nxt == '0) ? ST_ISSUE : ST_DRAIN;
            else if (coef_take) state_nxt = ST_COLLECT;
         end
         ST_DRAIN: if (fifo_cnt_nxt == '0) state_nxt = ST_ISSUE;
         ST_ISSUE: if (last_issue) state_nxt = ST_GAP;
         ST_GAP:   state_nxt = ST_STREAM;
         default:  state_nxt = ST_STREAM;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_STREAM;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt_nxt;
      end
   end

   // NOTE: storage arrays are not reset; pointers and counts decide which entries are live.
   always_ff @(posedge clk) begin
      if (push)      fifo_mem[wr_ptr] <= bus.host_data;
      if (coef_take) coef_mem[coef_cnt[IX_W-1:0]] <= bus.host_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         coef_cnt  <= '0;
         issue_idx <= '0;
      end else begin
         if (abort)                coef_cnt <= '0;
         else if (coef_take)       coef_cnt <= coef_cnt + 1'b1;
         else if (state == ST_GAP) coef_cnt <= '0;
         if (state == ST_ISSUE) issue_idx <= last_issue ? '0 : issue_idx + 1'b1;
      end
   end

   // FIR-facing registers: a pop and a burst cycle can never coincide.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.fir_tdata      <= '0;
         bus.fir_tvalid     <= 1'b0;
         bus.fir_set_coeffs <= 1'b0;
         ovf                <= 1'b0;
         coef_err           <= 1'b0;
      end else begin
         bus.fir_tvalid     <= pop;
         bus.fir_set_coeffs <= (state == ST_ISSUE);
         if (pop)                    bus.fir_tdata <= fifo_mem[rd_ptr];
         else if (state == ST_ISSUE) bus.fir_tdata <= coef_mem[issue_idx];
         if (bus.host_valid && !bus.host_mode && accepting && fifo_full) ovf <= 1'b1;
         if (abort) coef_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fir_in_seq.sv
// Randomized and directed check of fir_in_seq against a queue-based behavioural model.
module tb_fir_in_seq;
   logic clk = 1'b0;
   logic reset;
   logic ovf, coef_err;

   fir_in_seq_if #(.DATA_W(6)) bus ();

   fir_in_seq #(.DATA_W(6), .FIFO_DEPTH(4), .COEF_WORDS(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .ovf      (ovf),
      .coef_err (coef_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model: sample queue, held coefficient words, burst position.
   logic [5:0] m_q[$];
   logic [5:0] m_cw[$];
   int         m_issue;
   bit         m_gap;
   logic [5:0] e_tdata;
   bit         e_tvalid, e_set, e_ovf, e_err;

   logic [5:0] obs_s[$];
   logic [5:0] obs_c[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_cw.delete();
      m_issue  = -1;
      m_gap    = 1'b0;
      e_tdata  = '0;
      e_tvalid = 1'b0;
      e_set    = 1'b0;
      e_ovf    = 1'b0;
      e_err    = 1'b0;
   endtask

   function automatic bit model_ready();
      return !m_gap && (m_issue < 0) && (m_cw.size() < 3) && (m_q.size() < 4);
   endfunction

   task automatic model_edge(input logic v, input logic md, input logic [5:0] d);
      bit rdy, pop;
      rdy = model_ready();
      if (m_gap) begin
         e_tvalid = 1'b0;
         e_set    = 1'b0;
         m_cw.delete();
         m_gap    = 1'b0;
      end else if (m_issue >= 0) begin
         e_tdata  = m_cw[m_issue];
         e_set    = 1'b1;
         e_tvalid = 1'b0;
         m_issue++;
         if (m_issue == 3) begin
            m_issue = -1;
            m_gap   = 1'b1;
         end
      end else begin
         e_set = 1'b0;
         if (v && !md && m_q.size() == 4 && m_cw.size() < 3) e_ovf = 1'b1;
         pop      = (m_q.size() > 0) && (m_cw.size() == 0 || m_cw.size() == 3);
         e_tvalid = pop;
         if (pop) e_tdata = m_q.pop_front();
         if (v && rdy && !md) begin
            m_q.push_back(d);
            if (m_cw.size() > 0) begin
               m_cw.delete();
               e_err = 1'b1;
            end
         end else if (v && rdy && md) begin
            m_cw.push_back(d);
         end
         if (m_cw.size() == 3 && m_q.size() == 0) m_issue = 0;
      end
   endtask

   task automatic step(input logic v, input logic md, input logic [5:0] d);
      bus.host_valid = v;
      bus.host_mode  = md;
      bus.host_data  = d;
      #1;
      check("host_ready", bus.host_ready, model_ready());
      model_edge(v, md, d);
      @(posedge clk);
      #1;
      check("fir_tvalid", bus.fir_tvalid, e_tvalid);
      check("fir_set_coeffs", bus.fir_set_coeffs, e_set);
      check("fir_tdata", bus.fir_tdata, e_tdata);
      check("ovf", ovf, e_ovf);
      check("coef_err", coef_err, e_err);
      if (bus.fir_tvalid)     obs_s.push_back(bus.fir_tdata);
      if (bus.fir_set_coeffs) obs_c.push_back(bus.fir_tdata);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'h00);
   endtask

   task automatic clear_obs();
      obs_s.delete();
      obs_c.delete();
   endtask

   initial begin
      model_reset();
      reset          = 1'b0;
      bus.host_valid = 1'b1;
      bus.host_mode  = 1'b0;
      bus.host_data  = 6'h15;
      #12;
      check("rst_ready", bus.host_ready, 1'b0);
      check("rst_tdata", bus.fir_tdata, 6'h00);
      check("rst_tvalid", bus.fir_tvalid, 1'b0);
      check("rst_set", bus.fir_set_coeffs, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_err", coef_err, 1'b0);
      reset = 1'b1;

      // Single sample latency
      step(1'b1, 1'b0, 6'h15);
      check("t1_not_yet", bus.fir_tvalid, 1'b0);
      step(1'b0, 1'b0, 6'h00);
      check("t1_tvalid", bus.fir_tvalid, 1'b1);
      check("t1_tdata", bus.fir_tdata, 6'h15);
      step(1'b0, 1'b0, 6'h00);
      check("t1_tvalid_low", bus.fir_tvalid, 1'b0);

      // Back-to-back samples 1..6
      clear_obs();
      for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 6'(i));
      idle(2);
      check("t2_count", obs_s.size(), 6);
      for (int i = 0; i < 6; i++) check("t2_data", obs_s[i], i + 1);
      check("t2_ovf", ovf, 1'b0);

      // Samples pushed behind a held coefficient word, with host_valid kept high
      clear_obs();
      step(1'b1, 1'b1, 6'h01);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'(6'h09 + i));
      idle(3);
      check("t3_count", obs_s.size(), 4);
      for (int i = 0; i < 4; i++) check("t3_data", obs_s[i], 6'h09 + i);

      // Reset so the following load starts with clear sticky flags
      reset = 1'b0;
      model_reset();
      #3;
      reset = 1'b1;

      // Coefficient load with pending samples
      clear_obs();
      step(1'b1, 1'b0, 6'h07);
      step(1'b1, 1'b0, 6'h08);
      step(1'b1, 1'b1, 6'h3F);
      step(1'b1, 1'b1, 6'h00);
      step(1'b1, 1'b1, 6'h15);
      idle(6);
      check("t4_samples", obs_s.size(), 2);
      check("t4_s0", obs_s[0], 6'h07);
      check("t4_s1", obs_s[1], 6'h08);
      check("t4_coefs", obs_c.size(), 3);
      check("t4_c0", obs_c[0], 6'h3F);
      check("t4_c1", obs_c[1], 6'h00);
      check("t4_c2", obs_c[2], 6'h15);

      // Aborted load, then a full load
      clear_obs();
      step(1'b1, 1'b1, 6'h2A);
      step(1'b1, 1'b0, 6'h05);
      idle(2);
      check("t5_err", coef_err, 1'b1);
      check("t5_sample", obs_s.size(), 1);
      check("t5_no_burst", obs_c.size(), 0);
      step(1'b1, 1'b1, 6'h11);
      step(1'b1, 1'b1, 6'h22);
      step(1'b1, 1'b1, 6'h33);
      idle(5);
      check("t5_burst", obs_c.size(), 3);
      check("t5_c2", obs_c[2], 6'h33);

      // Reset after the second burst cycle
      clear_obs();
      step(1'b1, 1'b1, 6'h0A);
      step(1'b1, 1'b1, 6'h0B);
      step(1'b1, 1'b1, 6'h0C);
      for (int i = 0; i < 6 && obs_c.size() < 2; i++) idle(1);
      check("t6_two_cycles", obs_c.size(), 2);
      #2;
      reset = 1'b0;
      #1;
      check("t6_set_drop", bus.fir_set_coeffs, 1'b0);
      check("t6_ready_low", bus.host_ready, 1'b0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      step(1'b1, 1'b0, 6'h2C);
      step(1'b0, 1'b0, 6'h00);
      check("t6_after_tdata", bus.fir_tdata, 6'h2C);
      clear_obs();
      step(1'b1, 1'b1, 6'h01);
      step(1'b1, 1'b1, 6'h02);
      step(1'b1, 1'b1, 6'h03);
      idle(5);
      check("t6_fresh_burst", obs_c.size(), 3);
      check("t6_fresh_c0", obs_c[0], 6'h01);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25, 6'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
